// File: rtl/sub2_pkg.sv
// Shared types for the digit-serial subtractor.
// Holds FSM encoding, digit type and digit size.
package sub2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [1:0] digit_t;

  localparam int DIGIT_BITS = 2;

endpackage

// File: rtl/sub2.sv
// 2-bit LUT borrow cell: {m} - {s} - bin.
// Outputs are forced to zero when not enabled.
module sub2
  import sub2_pkg::*;
(
  input  logic   rx_enable,
  input  logic   rx_borrowflag,
  input  digit_t rx_minuend,
  input  digit_t rx_subtrahend,
  output digit_t tx_difference,
  output logic   tx_borrowflag
);

  logic [4:0] key;
  logic [2:0] lut;

  assign key = {rx_borrowflag, rx_minuend, rx_subtrahend};

  // Lookup {borrow_out, digit} for every input combination
  always_comb begin
    lut = 3'b000;
    unique case (key)
      5'b0_00_00: lut = 3'b000;
      5'b0_00_01: lut = 3'b111;
      5'b0_00_10: lut = 3'b110;
      5'b0_00_11: lut = 3'b101;
      5'b0_01_00: lut = 3'b001;
      5'b0_01_01: lut = 3'b000;
      5'b0_01_10: lut = 3'b111;
      5'b0_01_11: lut = 3'b110;
      5'b0_10_00: lut = 3'b010;
      5'b0_10_01: lut = 3'b001;
      5'b0_10_10: lut = 3'b000;
      5'b0_10_11: lut = 3'b111;
      5'b0_11_00: lut = 3'b011;
      5'b0_11_01: lut = 3'b010;
      5'b0_11_10: lut = 3'b001;
      5'b0_11_11: lut = 3'b000;
      5'b1_00_00: lut = 3'b111;
      5'b1_00_01: lut = 3'b110;
      5'b1_00_10: lut = 3'b101;
      5'b1_00_11: lut = 3'b100;
      5'b1_01_00: lut = 3'b000;
      5'b1_01_01: lut = 3'b111;
      5'b1_01_10: lut = 3'b110;
      5'b1_01_11: lut = 3'b101;
      5'b1_10_00: lut = 3'b001;
      5'b1_10_01: lut = 3'b000;
      5'b1_10_10: lut = 3'b111;
      5'b1_10_11: lut = 3'b110;
      5'b1_11_00: lut = 3'b010;
      5'b1_11_01: lut = 3'b001;
      5'b1_11_10: lut = 3'b000;
      5'b1_11_11: lut = 3'b111;
    endcase
  end

  assign tx_difference = rx_enable ? lut[1:0] : 2'b00;
  assign tx_borrowflag = rx_enable ? lut[2]   : 1'b0;

endmodule

// File: rtl/serial_sub2.sv
// Digit-serial WIDTH-bit subtractor, 2 bits per clock, LSB-first.
// Valid/ready on operands and result; one shared borrow cell.
module serial_sub2
  import sub2_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             rx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] rx_minuend,
  input  logic [WIDTH-1:0] rx_subtrahend,
  input  logic             rx_borrowflag,
  output logic             tx_valid,
  input  logic             rx_ready,
  output logic [WIDTH-1:0] tx_difference,
  output logic             tx_borrowflag,
  output logic             tx_zeroflag
);

  localparam int NDIG = WIDTH / DIGIT_BITS;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("serial_sub2: WIDTH must be even and >= 2");
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bor_q, bor_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] sub_q, sub_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [WIDTH+1:0] diff_sh;
  digit_t           cell_dig;
  logic             cell_bor;
  logic             run;

  assign run = (state_q == RUN);

  sub2 u_cell (
    .rx_enable     (run),
    .rx_borrowflag (bor_q),
    .rx_minuend    (min_q[1:0]),
    .rx_subtrahend (sub_q[1:0]),
    .tx_difference (cell_dig),
    .tx_borrowflag (cell_bor)
  );

  assign diff_sh = {cell_dig, diff_q};

  // Next-state: accept, step one digit, or hand off the result
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bor_d   = bor_q;
    zero_d  = zero_q;
    min_d   = min_q;
    sub_d   = sub_q;
    diff_d  = diff_q;
    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          min_d   = rx_minuend;
          sub_d   = rx_subtrahend;
          bor_d   = rx_borrowflag;
          zero_d  = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d = diff_sh[WIDTH+1:2];
        bor_d  = cell_bor;
        zero_d = zero_q & (cell_dig == 2'b00);
        min_d  = min_q >> DIGIT_BITS;
        sub_d  = sub_q >> DIGIT_BITS;
        if (cnt_q == CW'(NDIG - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (rx_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bor_q   <= 1'b0;
      zero_q  <= 1'b0;
      min_q   <= '0;
      sub_q   <= '0;
      diff_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bor_q   <= bor_d;
      zero_q  <= zero_d;
      min_q   <= min_d;
      sub_q   <= sub_d;
      diff_q  <= diff_d;
    end
  end

  assign tx_ready      = (state_q == IDLE);
  assign tx_valid      = (state_q == DONE);
  assign tx_difference = diff_q;
  assign tx_borrowflag = bor_q;
  assign tx_zeroflag   = zero_q;

endmodule

// File: tb/tb_serial_sub2.sv
// Directed and randomized checks for serial_sub2.
// Expected values come from constants and a 9-bit reference.
module tb_serial_sub2;

  logic       aclk;
  logic       areset;
  logic       rx_valid;
  logic       tx_ready;
  logic [7:0] rx_minuend;
  logic [7:0] rx_subtrahend;
  logic       rx_borrowflag;
  logic       tx_valid;
  logic       rx_ready;
  logic [7:0] tx_difference;
  logic       tx_borrowflag;
  logic       tx_zeroflag;

  int total;
  int bad;

  serial_sub2 #(.WIDTH(8)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .rx_valid      (rx_valid),
    .tx_ready      (tx_ready),
    .rx_minuend    (rx_minuend),
    .rx_subtrahend (rx_subtrahend),
    .rx_borrowflag (rx_borrowflag),
    .tx_valid      (tx_valid),
    .rx_ready      (rx_ready),
    .tx_difference (tx_difference),
    .tx_borrowflag (tx_borrowflag),
    .tx_zeroflag   (tx_zeroflag)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic run_op(input  logic [7:0] a,
                        input  logic [7:0] b,
                        input  logic       c,
                        input  int         pre,
                        input  int         hold,
                        input  bit         poke,
                        output logic [7:0] d,
                        output logic       bo,
                        output logic       z,
                        output int         lat);
    int n;
    repeat (pre) step();
    rx_minuend    = a;
    rx_subtrahend = b;
    rx_borrowflag = c;
    rx_valid      = 1'b1;
    n = 0;
    while (!tx_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
    step();
    rx_valid      = 1'b0;
    rx_minuend    = 8'($urandom);
    rx_subtrahend = 8'($urandom);
    rx_borrowflag = 1'($urandom);
    lat = 0;
    while (!tx_valid && lat < 20) begin
      rx_valid = (poke && lat == 1);
      step();
      lat++;
    end
    rx_valid = 1'b0;
    if (lat >= 20) chk("valid_timeout", 32'd1, 32'd0);
    d  = tx_difference;
    bo = tx_borrowflag;
    z  = tx_zeroflag;
    repeat (hold) begin
      step();
      chk("hold_valid", 32'(tx_valid), 32'd1);
      chk("hold_rdy", 32'(tx_ready), 32'd0);
      chk("hold_diff", 32'(tx_difference), 32'(d));
      chk("hold_bor", 32'(tx_borrowflag), 32'(bo));
      chk("hold_zero", 32'(tx_zeroflag), 32'(z));
    end
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    chk("post_ready", 32'(tx_ready), 32'd1);
    chk("post_valid", 32'(tx_valid), 32'd0);
  endtask

  logic [7:0] d;
  logic       bo;
  logic       z;
  int         lat;
  logic [8:0] ref9;

  initial begin
    total         = 0;
    bad           = 0;
    areset        = 1'b1;
    rx_valid      = 1'b0;
    rx_ready      = 1'b0;
    rx_minuend    = '0;
    rx_subtrahend = '0;
    rx_borrowflag = 1'b0;
    step();
    step();
    areset = 1'b0;
    step();

    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_diff", 32'(tx_difference), 32'd0);
    chk("rst_bor", 32'(tx_borrowflag), 32'd0);
    chk("rst_zero", 32'(tx_zeroflag), 32'd0);

    run_op(8'h5A, 8'h3C, 1'b0, 0, 0, 1'b0, d, bo, z, lat);
    chk("5a_diff", 32'(d), 32'h1E);
    chk("5a_bor", 32'(bo), 32'd0);
    chk("5a_zero", 32'(z), 32'd0);
    chk("5a_lat", 32'(lat), 32'd4);

    run_op(8'h00, 8'h01, 1'b0, 0, 0, 1'b0, d, bo, z, lat);
    chk("00_diff", 32'(d), 32'hFF);
    chk("00_bor", 32'(bo), 32'd1);
    chk("00_zero", 32'(z), 32'd0);

    run_op(8'hFF, 8'hFF, 1'b1, 0, 0, 1'b0, d, bo, z, lat);
    chk("ff_diff", 32'(d), 32'hFF);
    chk("ff_bor", 32'(bo), 32'd1);

    run_op(8'h42, 8'h41, 1'b1, 0, 0, 1'b0, d, bo, z, lat);
    chk("42_diff", 32'(d), 32'h00);
    chk("42_bor", 32'(bo), 32'd0);
    chk("42_zero", 32'(z), 32'd1);

    run_op(8'h9C, 8'h27, 1'b0, 1, 3, 1'b1, d, bo, z, lat);
    chk("bp_diff", 32'(d), 32'h75);
    chk("bp_bor", 32'(bo), 32'd0);
    chk("bp_lat", 32'(lat), 32'd4);
    repeat (6) begin
      step();
      chk("no_extra", 32'(tx_valid), 32'd0);
    end

    rx_minuend    = 8'h77;
    rx_subtrahend = 8'h11;
    rx_borrowflag = 1'b0;
    rx_valid      = 1'b1;
    step();
    rx_valid = 1'b0;
    step();
    areset = 1'b1;
    step();
    chk("mid_ready", 32'(tx_ready), 32'd1);
    chk("mid_valid", 32'(tx_valid), 32'd0);
    chk("mid_diff", 32'(tx_difference), 32'd0);
    chk("mid_bor", 32'(tx_borrowflag), 32'd0);
    chk("mid_zero", 32'(tx_zeroflag), 32'd0);
    areset = 1'b0;
    step();
    chk("mid_nores", 32'(tx_valid), 32'd0);

    run_op(8'h10, 8'h01, 1'b0, 0, 0, 1'b0, d, bo, z, lat);
    chk("10_diff", 32'(d), 32'h0F);
    chk("10_bor", 32'(bo), 32'd0);

    for (int i = 0; i < 1500; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      logic       c;
      a = 8'($urandom);
      b = 8'($urandom);
      c = 1'($urandom);
      if (i < 4) begin
        a = (i[0]) ? 8'h00 : 8'hFF;
        b = (i[1]) ? 8'hFF : 8'h00;
      end
      ref9 = {1'b0, a} - {1'b0, b} - {8'd0, c};
      run_op(a, b, c, $urandom_range(0, 2), $urandom_range(0, 3),
             1'($urandom), d, bo, z, lat);
      chk("rnd_diff", 32'(d), 32'(ref9[7:0]));
      chk("rnd_bor", 32'(bo), 32'(ref9[8]));
      chk("rnd_zero", 32'(z), 32'(ref9[7:0] == 8'h00));
      chk("rnd_lat", 32'(lat), 32'd4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
